// File: rtl/bcd_disp_pkg.sv
// Shared segment codes, anode constants and scan-state encoding for the BCD display scanner.
// Pure definitions: no logic, no latency.
package bcd_disp_pkg;

  // Segment order {g,f,e,d,c,b,a}, active low
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [2:0] AN_OFF = 3'b111;

  typedef enum logic {
    S_BLANK = 1'b0,
    S_DRIVE = 1'b1
  } scan_state_e;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-low 7-segment decoder; non-BCD nibbles show a dash.
// Zero latency, no flow control; blank overrides the nibble.
module bcd_to_seg7
  import bcd_disp_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      case (nibble)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// 3-digit multiplexed 7-segment scanner; digits commit only at frame wrap so the display never tears.
// Outputs registered (1 cycle after state/idx); load is always accepted, last load before commit wins.
module bcd_display_scanner
  import bcd_disp_pkg::*;
#(
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] hundreds,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  input  logic       blank_lz,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       frame_done
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  scan_state_e   state_q, state_d;
  logic [3:0]    pend_h_q, pend_t_q, pend_o_q, pend_h_d, pend_t_d, pend_o_d;
  logic          pend_vld_q, pend_vld_d;
  logic [3:0]    disp_h_q, disp_t_q, disp_o_q, disp_h_d, disp_t_d, disp_o_d;
  logic [6:0]    seg_q, seg_d;
  logic [2:0]    an_q, an_d;
  logic          frame_done_q, frame_done_d;

  logic          slot_end, frame_end, commit;
  logic [3:0]    cur_nib;
  logic          cur_blank;
  logic [6:0]    dec_seg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      state_q      <= S_BLANK;
      pend_h_q     <= 4'd0;
      pend_t_q     <= 4'd0;
      pend_o_q     <= 4'd0;
      pend_vld_q   <= 1'b0;
      disp_h_q     <= 4'd0;
      disp_t_q     <= 4'd0;
      disp_o_q     <= 4'd0;
      seg_q        <= SEG_BLANK;
      an_q         <= AN_OFF;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      state_q      <= state_d;
      pend_h_q     <= pend_h_d;
      pend_t_q     <= pend_t_d;
      pend_o_q     <= pend_o_d;
      pend_vld_q   <= pend_vld_d;
      disp_h_q     <= disp_h_d;
      disp_t_q     <= disp_t_d;
      disp_o_q     <= disp_o_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Prescaler, scan index and the load/commit double buffer
  always_comb begin
    slot_end  = (cnt_q == CNT_LAST);
    frame_end = slot_end && (idx_q == 2'd2);
    commit    = frame_end && pend_vld_q;

    cnt_d = slot_end ? '0 : cnt_q + CW'(1);
    idx_d = idx_q;
    if (slot_end) idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;

    // Commit reads the pre-edge pending values, so a coincident load lands in the next frame
    disp_h_d = commit ? pend_h_q : disp_h_q;
    disp_t_d = commit ? pend_t_q : disp_t_q;
    disp_o_d = commit ? pend_o_q : disp_o_q;

    pend_h_d   = load ? hundreds : pend_h_q;
    pend_t_d   = load ? tens     : pend_t_q;
    pend_o_d   = load ? ones     : pend_o_q;
    pend_vld_d = load ? 1'b1 : (commit ? 1'b0 : pend_vld_q);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BLANK: if (cnt_q == BLANK_LAST) state_d = S_DRIVE;
      S_DRIVE: if (slot_end)            state_d = S_BLANK;
      default: state_d = S_BLANK;
    endcase
  end

  // A dash in hundreds is non-zero, so it never lets tens blank
  always_comb begin
    case (idx_q)
      2'd0:    cur_nib = disp_o_q;
      2'd1:    cur_nib = disp_t_q;
      default: cur_nib = disp_h_q;
    endcase
    cur_blank = blank_lz &&
                (((idx_q == 2'd2) && (disp_h_q == 4'd0)) ||
                 ((idx_q == 2'd1) && (disp_h_q == 4'd0) && (disp_t_q == 4'd0)));
  end

  bcd_to_seg7 u_dec (
    .nibble (cur_nib),
    .blank  (cur_blank),
    .seg    (dec_seg)
  );

  always_comb begin
    an_d         = AN_OFF;
    seg_d        = SEG_BLANK;
    frame_done_d = frame_end;
    if (state_q == S_DRIVE) begin
      an_d  = ~(3'b001 << idx_q);
      seg_d = dec_seg;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Randomized bench for bcd_display_scanner with a cycle-indexed reference model of the scan schedule.
module tb_bcd_display_scanner;

  localparam int CLK_DIV = 8;
  localparam int BLANK   = 2;
  localparam int FRAME   = 3 * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load;
  logic [3:0] hundreds, tens, ones;
  logic       blank_lz;
  logic [6:0] seg;
  logic [2:0] an;
  logic       frame_done;

  always #5 clk = ~clk;

  bcd_display_scanner #(.CLK_DIV(CLK_DIV), .BLANK_CYCLES(BLANK)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .hundreds   (hundreds),
    .tens       (tens),
    .ones       (ones),
    .blank_lz   (blank_lz),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model: n = rising edges since reset release; digit arrays indexed 0=ones,1=tens,2=hundreds
  int         n;
  logic [3:0] m_disp [3];
  logic [3:0] m_pend [3];
  bit         m_pvld;
  logic [6:0] exp_seg;
  logic [2:0] exp_an;
  logic       exp_fd;
  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  task automatic model_reset();
    n = 0;
    m_pvld = 1'b0;
    for (int k = 0; k < 3; k++) begin
      m_disp[k] = 4'd0;
      m_pend[k] = 4'd0;
    end
  endtask

  // Advance one clock; expected outputs after edge n come from the schedule position before the edge
  task automatic step();
    int c, s;
    logic [3:0] d;
    bit bl;
    @(posedge clk);
    n++;
    c = (n - 1) % CLK_DIV;
    s = ((n - 1) / CLK_DIV) % 3;
    exp_an  = 3'b111;
    exp_seg = 7'h7F;
    if (c >= BLANK) begin
      exp_an[s] = 1'b0;
      d  = m_disp[s];
      bl = blank_lz && ((s == 2 && m_disp[2] == 4'd0) ||
                        (s == 1 && m_disp[2] == 4'd0 && m_disp[1] == 4'd0));
      exp_seg = bl ? 7'h7F : (d <= 4'd9 ? seg_tab[d] : 7'h3F);
    end
    exp_fd = (n % FRAME == 0);
    if (exp_fd && m_pvld) begin
      m_disp = m_pend;
      m_pvld = 1'b0;
    end
    if (load) begin
      m_pend[0] = ones;
      m_pend[1] = tens;
      m_pend[2] = hundreds;
      m_pvld = 1'b1;
    end
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic drive_load(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
    hundreds = h;
    tens     = t;
    ones     = o;
    load     = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({an, seg, frame_done} !== {3'b111, 7'h7F, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state an=%b seg=%h fd=%b expected an=111 seg=7f fd=0", an, seg, frame_done);
    end
    release_reset();
    for (int i = 1; i <= 3; i++) begin
      step();
      vectors++;
      if (an !== ((i == 3) ? 3'b110 : 3'b111)) begin
        miscompares++;
        $display("FAIL first_anode edge=%0d an=%b expected %b", i, an, (i == 3) ? 3'b110 : 3'b111);
      end
    end
  endtask

  task automatic test_first_frame();
    int base;
    blank_lz = 1'b0;
    drive_load(4'd1, 4'd2, 4'd3);
    step();
    load = 1'b0;
    base = ((n / FRAME) + 1) * FRAME;
    while (n < base + FRAME) begin
      step();
      vectors++;
      if ({an, seg, frame_done} !== {exp_an, exp_seg, exp_fd}) begin
        miscompares++;
        $display("FAIL first_frame n=%0d an=%b seg=%h fd=%b expected an=%b seg=%h fd=%b",
                 n, an, seg, frame_done, exp_an, exp_seg, exp_fd);
      end
      if (n == base + 3 || n == base + 11 || n == base + 19) begin
        vectors++;
        if ({an, seg} !== ((n == base + 3) ? {3'b110, 7'h30} :
                           (n == base + 11) ? {3'b101, 7'h24} : {3'b011, 7'h79})) begin
          miscompares++;
          $display("FAIL first_frame_spot n=%0d an=%b seg=%h", n, an, seg);
        end
      end
    end
  endtask

  task automatic test_lz();
    logic [3:0] o;
    blank_lz = 1'b1;
    for (int r = 0; r < 2; r++) begin
      o = (r == 0) ? 4'd7 : 4'd0;
      drive_load(4'd0, 4'd0, o);
      step();
      load = 1'b0;
      do begin
        step();
      end while (n % FRAME != 0);
      repeat (FRAME) begin
        step();
        vectors++;
        if ({an, seg, frame_done} !== {exp_an, exp_seg, exp_fd}) begin
          miscompares++;
          $display("FAIL lz_blank r=%0d n=%0d an=%b seg=%h fd=%b expected an=%b seg=%h fd=%b",
                   r, n, an, seg, frame_done, exp_an, exp_seg, exp_fd);
        end
        if (n % FRAME == 3 || n % FRAME == 11) begin
          vectors++;
          if (seg !== ((n % FRAME == 11) ? 7'h7F : (r == 0 ? 7'h78 : 7'h40))) begin
            miscompares++;
            $display("FAIL lz_spot r=%0d n=%0d seg=%h", r, n, seg);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int base;
    blank_lz = 1'b0;
    while (n % FRAME != FRAME - 2) step();
    drive_load(4'd0, 4'd0, 4'd5);
    step();
    drive_load(4'd0, 4'd0, 4'd9);
    step();
    load = 1'b0;
    base = n;
    repeat (2 * FRAME) begin
      step();
      vectors++;
      if ({an, seg, frame_done} !== {exp_an, exp_seg, exp_fd}) begin
        miscompares++;
        $display("FAIL back_to_back n=%0d an=%b seg=%h fd=%b expected an=%b seg=%h fd=%b",
                 n, an, seg, frame_done, exp_an, exp_seg, exp_fd);
      end
      if (n == base + 3 || n == base + FRAME + 3) begin
        vectors++;
        if (seg !== ((n == base + 3) ? 7'h12 : 7'h10)) begin
          miscompares++;
          $display("FAIL back_to_back_order n=%0d seg=%h", n, seg);
        end
      end
    end
  endtask

  task automatic test_invalid();
    int base;
    blank_lz = 1'b1;
    drive_load(4'hC, 4'd0, 4'hA);
    step();
    load = 1'b0;
    do begin
      step();
    end while (n % FRAME != 0);
    base = n;
    repeat (FRAME) begin
      step();
      vectors++;
      if ({an, seg, frame_done} !== {exp_an, exp_seg, exp_fd}) begin
        miscompares++;
        $display("FAIL invalid n=%0d an=%b seg=%h fd=%b expected an=%b seg=%h fd=%b",
                 n, an, seg, frame_done, exp_an, exp_seg, exp_fd);
      end
      if (n == base + 3 || n == base + 11 || n == base + 19) begin
        vectors++;
        if (seg !== ((n == base + 11) ? 7'h40 : 7'h3F)) begin
          miscompares++;
          $display("FAIL invalid_spot n=%0d seg=%h", n, seg);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    blank_lz = 1'b0;
    drive_load(4'd8, 4'd8, 4'd8);
    step();
    load = 1'b0;
    while (n % FRAME != 13) step();
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({an, seg, frame_done} !== {3'b111, 7'h7F, 1'b0}) begin
      miscompares++;
      $display("FAIL async_reset an=%b seg=%h fd=%b expected an=111 seg=7f fd=0", an, seg, frame_done);
    end
    release_reset();
    repeat (FRAME + 6) begin
      step();
      vectors++;
      if ({an, seg, frame_done} !== {exp_an, exp_seg, exp_fd}) begin
        miscompares++;
        $display("FAIL after_reset n=%0d an=%b seg=%h fd=%b expected an=%b seg=%h fd=%b",
                 n, an, seg, frame_done, exp_an, exp_seg, exp_fd);
      end
      if (n == 3 || n == FRAME + 3) begin
        vectors++;
        if ({an, seg} !== {3'b110, 7'h40}) begin
          miscompares++;
          $display("FAIL after_reset_spot n=%0d an=%b seg=%h expected an=110 seg=40", n, an, seg);
        end
      end
    end
  endtask

  task automatic test_free_run();
    int last_fd, pulses, exp_pulses;
    last_fd = 0;
    pulses = 0;
    exp_pulses = 0;
    repeat (4 * FRAME) begin
      load     = ($urandom_range(0, 4) == 0);
      hundreds = 4'($urandom_range(0, 15));
      tens     = 4'($urandom_range(0, 15));
      ones     = 4'($urandom_range(0, 15));
      blank_lz = 1'($urandom_range(0, 1));
      step();
      if (exp_fd) exp_pulses++;
      vectors++;
      if ({an, seg, frame_done} !== {exp_an, exp_seg, exp_fd}) begin
        miscompares++;
        $display("FAIL free_run n=%0d an=%b seg=%h fd=%b expected an=%b seg=%h fd=%b",
                 n, an, seg, frame_done, exp_an, exp_seg, exp_fd);
      end
      vectors++;
      if ($countones(~an) > 1) begin
        miscompares++;
        $display("FAIL anode_onehot n=%0d an=%b expected at most one low", n, an);
      end
      if (frame_done === 1'b1) begin
        pulses++;
        if (last_fd > 0) begin
          vectors++;
          if (n - last_fd !== FRAME) begin
            miscompares++;
            $display("FAIL frame_spacing n=%0d got %0d expected %0d", n, n - last_fd, FRAME);
          end
        end
        last_fd = n;
      end
    end
    load = 1'b0;
    vectors++;
    if (pulses !== exp_pulses) begin
      miscompares++;
      $display("FAIL frame_pulses got %0d expected %0d", pulses, exp_pulses);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    load     = 1'b0;
    hundreds = 4'd0;
    tens     = 4'd0;
    ones     = 4'd0;
    blank_lz = 1'b0;
    model_reset();
    test_reset();
    test_first_frame();
    test_lz();
    test_back_to_back();
    test_invalid();
    test_async_reset();
    test_free_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
